// File: rtl/bist_pkg.sv
// Shared types and constants for the logic BIST controller.
// The LFSR tap mask and MISR polynomial are fixed here so the top and the compactor agree.
package bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SETTLE  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_DONE    = 2'd3
    } bist_state_e;

    localparam int          PAT_W_DEF  = 8;
    localparam int          RSP_W_DEF  = 6;
    localparam int          MISR_W_DEF = 16;
    localparam logic [7:0]  LFSR_TAPS  = 8'hB8;
    localparam logic [15:0] MISR_POLY  = 16'h1021;

endpackage

// File: rtl/bist_misr.sv
// Multiple-input signature register: shift-left with polynomial feedback, XOR in data_in.
// One-cycle update when enable is high; clear has priority over enable, no backpressure.
module bist_misr #(
    parameter int           W    = 16,
    parameter logic [W-1:0] POLY = 16'h1021
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clear,
    input  logic         enable,
    input  logic [W-1:0] data_in,
    output logic [W-1:0] sig_out
);

    logic [W-1:0] sig_q;
    logic [W-1:0] sig_d;

    always_comb begin
        sig_d = sig_q;
        if (clear) begin
            sig_d = '0;
        end else if (enable) begin
            sig_d = {sig_q[W-2:0], 1'b0} ^ (sig_q[W-1] ? POLY : '0) ^ data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sig_q <= '0;
        end else begin
            sig_q <= sig_d;
        end
    end

    assign sig_out = sig_q;

endmodule

// File: rtl/logic_bist_ctrl.sv
// Logic BIST controller: LFSR stimulus, per-pattern settle wait, MISR compaction, golden compare.
// A run spans NUM_PATTERNS*(SETTLE_CYCLES+1)+1 cycles; no backpressure, start is ignored unless idle.
module logic_bist_ctrl
    import bist_pkg::*;
#(
    parameter int               PAT_W         = PAT_W_DEF,
    parameter int               RSP_W         = RSP_W_DEF,
    parameter int               NUM_PATTERNS  = 255,
    parameter int               SETTLE_CYCLES = 2,
    parameter logic [PAT_W-1:0] LFSR_SEED     = 8'h01,
    parameter int               MISR_W        = MISR_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic [MISR_W-1:0] golden,
    input  logic [RSP_W-1:0]  dut_out,
    output logic [PAT_W-1:0]  dut_in,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [MISR_W-1:0] signature,
    output logic [7:0]        pat_count
);

    localparam int CNT_W = $clog2(SETTLE_CYCLES + 1);

    bist_state_e       state_q, state_d;
    logic [PAT_W-1:0]  lfsr_q, lfsr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [7:0]        pcnt_q, pcnt_d;
    logic              pass_q, pass_d;
    logic              misr_clear;
    logic              misr_en;
    logic [MISR_W-1:0] misr_sig;

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        cnt_d      = cnt_q;
        pcnt_d     = pcnt_q;
        pass_d     = pass_q;
        misr_clear = 1'b0;
        misr_en    = 1'b0;
        if (abort) begin
            // Abort freezes signature/count; an abort while idle is a no-op that also blocks start.
            if (state_q != ST_IDLE) begin
                state_d = ST_IDLE;
                pass_d  = 1'b0;
            end
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        state_d    = ST_SETTLE;
                        lfsr_d     = LFSR_SEED;
                        cnt_d      = '0;
                        pcnt_d     = '0;
                        pass_d     = 1'b0;
                        misr_clear = 1'b1;
                    end
                end
                ST_SETTLE: begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(SETTLE_CYCLES - 1)) begin
                        state_d = ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    misr_en = 1'b1;
                    pcnt_d  = pcnt_q + 8'd1;
                    lfsr_d  = {lfsr_q[PAT_W-2:0], ^(lfsr_q & LFSR_TAPS)};
                    cnt_d   = '0;
                    state_d = (pcnt_q == 8'(NUM_PATTERNS - 1)) ? ST_DONE : ST_SETTLE;
                end
                ST_DONE: begin
                    pass_d  = (misr_sig == golden);
                    state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            lfsr_q  <= '0;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            pass_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            pass_q  <= pass_d;
        end
    end

    bist_misr #(
        .W    (MISR_W),
        .POLY (MISR_POLY)
    ) u_misr (
        .clk     (clk),
        .rst     (rst),
        .clear   (misr_clear),
        .enable  (misr_en),
        .data_in ({{(MISR_W - RSP_W){1'b0}}, dut_out}),
        .sig_out (misr_sig)
    );

    // The LFSR register is the applied pattern, so dut_in holds it through idle.
    assign dut_in    = lfsr_q;
    assign busy      = (state_q == ST_SETTLE) || (state_q == ST_CAPTURE);
    assign done      = (state_q == ST_DONE);
    assign pass      = pass_q;
    assign signature = misr_sig;
    assign pat_count = pcnt_q;

endmodule

// File: tb/tb_logic_bist_ctrl.sv
// Bench for logic_bist_ctrl: three instances (N=5/S=2, N=2/S=1, N=255/S=2 with a cloud model)
// checked every cycle against a timeline model, plus directed literal expectations.
module tb_logic_bist_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_v    [3];
    logic        start_v  [3];
    logic        abort_v  [3];
    logic [15:0] golden_v [3];
    logic [5:0]  dout_drv [3];
    logic [5:0]  cloud_out;
    logic [7:0]  din_v    [3];
    logic        busy_v   [3];
    logic        done_v   [3];
    logic        pass_v   [3];
    logic [15:0] sig_v    [3];
    logic [7:0]  pc_v     [3];

    int checks = 0;
    int errors = 0;

    int np_a [3] = '{5, 2, 255};
    int sp_a [3] = '{2, 1, 2};

    logic [7:0] scn1_pat [5] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h11};

    logic_bist_ctrl #(.NUM_PATTERNS(5), .SETTLE_CYCLES(2)) u0 (
        .clk(clk), .rst(rst_v[0]), .start(start_v[0]), .abort(abort_v[0]),
        .golden(golden_v[0]), .dut_out(dout_drv[0]), .dut_in(din_v[0]),
        .busy(busy_v[0]), .done(done_v[0]), .pass(pass_v[0]),
        .signature(sig_v[0]), .pat_count(pc_v[0]));

    logic_bist_ctrl #(.NUM_PATTERNS(2), .SETTLE_CYCLES(1)) u1 (
        .clk(clk), .rst(rst_v[1]), .start(start_v[1]), .abort(abort_v[1]),
        .golden(golden_v[1]), .dut_out(dout_drv[1]), .dut_in(din_v[1]),
        .busy(busy_v[1]), .done(done_v[1]), .pass(pass_v[1]),
        .signature(sig_v[1]), .pat_count(pc_v[1]));

    logic_bist_ctrl #(.NUM_PATTERNS(255), .SETTLE_CYCLES(2)) u2 (
        .clk(clk), .rst(rst_v[2]), .start(start_v[2]), .abort(abort_v[2]),
        .golden(golden_v[2]), .dut_out(cloud_out), .dut_in(din_v[2]),
        .busy(busy_v[2]), .done(done_v[2]), .pass(pass_v[2]),
        .signature(sig_v[2]), .pat_count(pc_v[2]));

    function automatic logic [5:0] cloud(input logic [7:0] v);
        logic a, b, c, d, e, f, g, h;
        {a, b, c, d, e, f, g, h} = v;
        return {(a & b) | c, d ^ e ^ f, ~(g & h), a | h, (b ^ g) & e, ~(c ^ d)};
    endfunction

    assign cloud_out = cloud(din_v[2]);

    function automatic logic [7:0] lfsr_step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [15:0] misr_step(input logic [15:0] m, input logic [5:0] r);
        logic [15:0] s;
        s = {m[14:0], 1'b0};
        if (m[15]) s = s ^ 16'h1021;
        return s ^ {10'd0, r};
    endfunction

    function automatic logic [15:0] ref_sig();
        logic [15:0] m;
        logic [7:0]  p;
        m = 16'h0000;
        p = 8'h01;
        for (int k = 0; k < 255; k++) begin
            m = misr_step(m, cloud(p));
            p = lfsr_step(p);
        end
        return m;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Timeline model: t_m counts edges since the accepted start; captures fall on multiples of S+1.
    bit          run_m  [3];
    int          t_m    [3];
    logic [7:0]  pat_m  [3];
    logic [15:0] misr_m [3];
    int          cnt_m  [3];
    bit          pass_m [3];
    int          m_per, m_last;
    logic [5:0]  m_rsp;

    initial begin
        for (int i = 0; i < 3; i++) begin
            run_m[i] = 1'b0; t_m[i] = 0; pat_m[i] = 8'h00;
            misr_m[i] = 16'h0000; cnt_m[i] = 0; pass_m[i] = 1'b0;
        end
    end

    always @(posedge clk) begin
        for (int i = 0; i < 3; i++) begin
            m_rsp  = (i == 2) ? cloud_out : dout_drv[i];
            m_per  = sp_a[i] + 1;
            m_last = np_a[i] * m_per;
            if (rst_v[i]) begin
                run_m[i] = 1'b0; t_m[i] = 0; pat_m[i] = 8'h00;
                misr_m[i] = 16'h0000; cnt_m[i] = 0; pass_m[i] = 1'b0;
            end else if (run_m[i]) begin
                if (abort_v[i]) begin
                    run_m[i]  = 1'b0;
                    pass_m[i] = 1'b0;
                end else begin
                    t_m[i] = t_m[i] + 1;
                    if (t_m[i] > m_last) begin
                        run_m[i]  = 1'b0;
                        pass_m[i] = (misr_m[i] == golden_v[i]);
                    end else if (t_m[i] % m_per == 0) begin
                        misr_m[i] = misr_step(misr_m[i], m_rsp);
                        cnt_m[i]  = cnt_m[i] + 1;
                        pat_m[i]  = lfsr_step(pat_m[i]);
                    end
                end
            end else if (start_v[i] && !abort_v[i]) begin
                run_m[i] = 1'b1; t_m[i] = 0; pat_m[i] = 8'h01;
                misr_m[i] = 16'h0000; cnt_m[i] = 0; pass_m[i] = 1'b0;
            end
        end
    end

    int  c_last;
    bit  c_busy, c_done;

    always @(negedge clk) begin
        for (int i = 0; i < 3; i++) begin
            c_last = np_a[i] * (sp_a[i] + 1);
            c_busy = run_m[i] && (t_m[i] < c_last);
            c_done = run_m[i] && (t_m[i] == c_last);
            chk($sformatf("u%0d dut_in", i),    32'(din_v[i]),  32'(pat_m[i]));
            chk($sformatf("u%0d busy", i),      32'(busy_v[i]), 32'(c_busy));
            chk($sformatf("u%0d done", i),      32'(done_v[i]), 32'(c_done));
            chk($sformatf("u%0d pass", i),      32'(pass_v[i]), 32'(pass_m[i]));
            chk($sformatf("u%0d signature", i), 32'(sig_v[i]),  32'(misr_m[i]));
            chk($sformatf("u%0d pat_count", i), 32'(pc_v[i]),   32'(cnt_m[i][7:0]));
        end
    end

    task automatic wait_done(input int i, input int budget);
        int n;
        n = 0;
        while (!done_v[i] && n < budget) begin
            tick(1);
            n++;
        end
        chk($sformatf("u%0d wait_done", i), 32'(done_v[i]), 32'd1);
    endtask

    task automatic run_scn1();
        golden_v[0] = 16'h0000;
        dout_drv[0] = 6'h00;
        start_v[0]  = 1'b1;
        tick(1);
        start_v[0]  = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) tick(3);
            chk($sformatf("scn1 pattern %0d", k), 32'(din_v[0]), 32'(scn1_pat[k]));
        end
        tick(3);
        chk("scn1 done", 32'(done_v[0]), 32'd1);
        chk("scn1 signature", 32'(sig_v[0]), 32'h0000);
        tick(1);
        chk("scn1 done low", 32'(done_v[0]), 32'd0);
        chk("scn1 pass", 32'(pass_v[0]), 32'd1);
        chk("scn1 pat_count", 32'(pc_v[0]), 32'd5);
    endtask

    bit seen [256];
    int ndist;
    int ndone;

    initial begin
        for (int i = 0; i < 3; i++) begin
            rst_v[i] = 1'b1; start_v[i] = 1'b0; abort_v[i] = 1'b0;
            golden_v[i] = 16'h0000; dout_drv[i] = 6'h00;
        end
        for (int v = 0; v < 256; v++) seen[v] = 1'b0;
        tick(3);
        for (int i = 0; i < 3; i++) rst_v[i] = 1'b0;

        chk("reset dut_in", 32'(din_v[0]), 32'h00);
        chk("reset busy", 32'(busy_v[0]), 32'd0);
        chk("reset signature", 32'(sig_v[0]), 32'h0000);

        run_scn1();

        golden_v[1] = 16'h0003;
        dout_drv[1] = 6'h01;
        start_v[1]  = 1'b1;
        tick(1);
        start_v[1]  = 1'b0;
        tick(2);
        chk("u1 first signature", 32'(sig_v[1]), 32'h0001);
        tick(2);
        chk("u1 done", 32'(done_v[1]), 32'd1);
        chk("u1 final signature", 32'(sig_v[1]), 32'h0003);
        tick(1);
        chk("u1 pass golden 3", 32'(pass_v[1]), 32'd1);
        golden_v[1] = 16'h0004;
        start_v[1]  = 1'b1;
        tick(1);
        start_v[1]  = 1'b0;
        tick(5);
        chk("u1 pass golden 4", 32'(pass_v[1]), 32'd0);

        start_v[0] = 1'b1;
        tick(1);
        start_v[0] = 1'b0;
        tick(9);
        chk("abort pattern 3", 32'(din_v[0]), 32'h08);
        abort_v[0] = 1'b1;
        tick(1);
        abort_v[0] = 1'b0;
        chk("abort busy", 32'(busy_v[0]), 32'd0);
        chk("abort pat_count", 32'(pc_v[0]), 32'd3);
        chk("abort pass", 32'(pass_v[0]), 32'd0);
        ndone = 0;
        for (int c = 0; c < 20; c++) begin
            if (done_v[0]) ndone++;
            tick(1);
        end
        chk("abort no done", 32'(ndone), 32'd0);

        start_v[0] = 1'b1;
        tick(1);
        start_v[0] = 1'b0;
        tick(3);
        start_v[0] = 1'b1;
        tick(1);
        start_v[0] = 1'b0;
        chk("busy start ignored dut_in", 32'(din_v[0]), 32'h02);
        chk("busy start ignored count", 32'(pc_v[0]), 32'd1);
        tick(1);
        rst_v[0] = 1'b1;
        tick(1);
        rst_v[0] = 1'b0;
        chk("midrun rst dut_in", 32'(din_v[0]), 32'h00);
        chk("midrun rst busy", 32'(busy_v[0]), 32'd0);
        chk("midrun rst done", 32'(done_v[0]), 32'd0);
        chk("midrun rst pass", 32'(pass_v[0]), 32'd0);
        chk("midrun rst signature", 32'(sig_v[0]), 32'h0000);
        chk("midrun rst pat_count", 32'(pc_v[0]), 32'd0);
        tick(1);
        run_scn1();

        golden_v[0] = 16'h0326;
        dout_drv[0] = 6'h2A;
        start_v[0]  = 1'b1;
        tick(1);
        start_v[0]  = 1'b0;
        wait_done(0, 40);
        chk("b2b run1 signature", 32'(sig_v[0]), 32'h0326);
        tick(1);
        chk("b2b run1 pass", 32'(pass_v[0]), 32'd1);
        start_v[0] = 1'b1;
        tick(1);
        start_v[0] = 1'b0;
        chk("b2b accepted", 32'(busy_v[0]), 32'd1);
        wait_done(0, 40);
        chk("b2b run2 signature", 32'(sig_v[0]), 32'h0326);
        tick(1);
        chk("b2b run2 pass", 32'(pass_v[0]), 32'd1);

        golden_v[2] = ref_sig();
        start_v[2]  = 1'b1;
        tick(1);
        start_v[2]  = 1'b0;
        chk("u2 first pattern", 32'(din_v[2]), 32'h01);
        for (int k = 0; k < 255; k++) begin
            if (k > 0) tick(3);
            seen[din_v[2]] = 1'b1;
        end
        tick(3);
        chk("u2 done", 32'(done_v[2]), 32'd1);
        chk("u2 pat_count", 32'(pc_v[2]), 32'd255);
        chk("u2 signature", 32'(sig_v[2]), 32'(golden_v[2]));
        tick(1);
        chk("u2 pass", 32'(pass_v[2]), 32'd1);
        ndist = 0;
        for (int v = 0; v < 256; v++) if (seen[v]) ndist++;
        chk("u2 distinct patterns", 32'(ndist), 32'd255);
        chk("u2 zero pattern seen", 32'(seen[0]), 32'd0);

        tick(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/logic_bist_ctrl.md
# logic_bist_ctrl

Built-in self-test controller for the 8-input / 6-output standard-cell logic cloud. It drives the cloud's inputs a..h from an LFSR pattern generator and waits a programmable settle time per pattern. It then compacts outputs y,z,p,q,r,s into a MISR signature and compares the final signature against a golden value. It sits between the test/config port and the combinational cloud, and owns the cloud's inputs during a test run.

## Interface
- `PAT_W`, 8, pattern width; drives a..h as `dut_in[7:0]` = {a,b,c,d,e,f,g,h}
- `RSP_W`, 6, response width; `dut_out[5:0]` = {y,z,p,q,r,s}
- `NUM_PATTERNS`, 255, patterns per run (1..255)
- `SETTLE_CYCLES`, 2, wait cycles per pattern before capture (≥1)
- `LFSR_SEED`, 8'h01, first pattern; must be nonzero
- `MISR_W`, 16, signature width

Ports:
- `clk`  in  1  single clock
- `rst`  in  1  synchronous, active-high reset
- `start`  in  1  begin run; sampled only in IDLE
- `abort`  in  1  cancel run; returns to IDLE
- `golden`  in  16  expected signature, sampled in DONE
- `dut_out`  in  6  cloud response
- `dut_in`  out  8  cloud stimulus
- `busy`  out  1  high in SETTLE/CAPTURE
- `done`  out  1  one-cycle pulse at run completion
- `pass`  out  1  signature==golden, valid from DONE until next start
- `signature`  out  16  MISR contents
- `pat_count`  out  8  patterns captured so far

## Operation
- States: IDLE, SETTLE, CAPTURE, DONE.
- IDLE + `start`:
  - lfsr←LFSR_SEED, dut_in←LFSR_SEED, misr←0, pat_count←0, pass←0, settle_cnt←0.
  - Next state SETTLE.
- SETTLE: settle_cnt increments. The edge at which settle_cnt==SETTLE_CYCLES−1 moves to CAPTURE.
- CAPTURE, one cycle:
  - At the exit edge, misr←{misr[14:0],0} ^ (misr[15] ? 16'h1021 : 0) ^ {10'b0, dut_out}.
  - pat_count++ and lfsr advances.
  - dut_in←next lfsr, settle_cnt←0.
  - If pat_count (pre-increment) == NUM_PATTERNS−1, go to DONE; otherwise go to SETTLE.
- LFSR: Fibonacci, fb = l[7]^l[5]^l[4]^l[3], next = {l[6:0], fb}. Sequence from 01: 01,02,04,08,11,…; period 255.
- DONE, one cycle: done=1, pass←(misr==golden). Next state IDLE.
- `dut_in` holds its last pattern in IDLE; `signature` and `pass` hold until the next `start`.
- `abort`:
  - Has priority over all transitions except `rst`, in any non-IDLE state.
  - Next state is IDLE, no `done` pulse, pass←0.
  - signature and pat_count freeze.
- `start` while not IDLE is ignored. `start`+`abort` together in IDLE: abort wins, and the state stays IDLE.
- Reset mid-run: immediate return to IDLE with all registers at reset values. No done pulse.

## Timing
- Reset values: dut_in=0, busy=0, done=0, pass=0, signature=0, pat_count=0, state IDLE.
- Let S=SETTLE_CYCLES and N=NUM_PATTERNS. Take `start` sampled at edge 0.
- Pattern k is applied at edge k·(S+1) and captured at edge (k+1)·(S+1). Each pattern is therefore stable S+1 cycles before sampling; the cloud's combinational depth must settle within S+1 periods.
- DONE is entered at edge N·(S+1). `done` and `pass` are visible in the following cycle, and the block is back in IDLE at edge N·(S+1)+1.
- Back-to-back runs: a `start` asserted in the first IDLE cycle after DONE is accepted.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Structure
- Package `bist_pkg`: state enum, LFSR tap mask (8'hB8), MISR polynomial (16'h1021), default widths.
- Sub-module `bist_misr`, parameterised by width and polynomial, with ports clear, enable, data_in, and sig_out. The LFSR and FSM stay in `logic_bist_ctrl`.

## Test plan
- Reset, then `start` with N=5, S=2, dut_out tied 0: dut_in sequence 01,02,04,08,11 at edges 0,3,6,9,12; done at cycle after edge 15; signature=0000; golden=0000 gives pass=1.
- N=2, S=1, dut_out held at 6'h01: signature 0001 after first capture, 0003 final; golden=0003 gives pass=1, golden=0004 gives pass=0.
- N=255 with the cloud behavioural model connected: all 255 dut_in values are distinct and nonzero; pat_count ends at 255; signature is compared against the reference-model value.
- `abort` during SETTLE of pattern 3: IDLE next cycle, busy=0, no done pulse, pat_count=3, pass=0.
- `start` pulsed while busy, then `rst` asserted mid-CAPTURE: the extra start has no effect; after reset all outputs are 0 and a fresh `start` reproduces the first scenario exactly.
- `start` asserted in the first IDLE cycle after done: the second run begins and produces the same signature as the first.
